instruction_decode: RTL and testbench
=====================================

Name: instruction_decode

Overview:
- LEGv8 (ARMv8 subset) decode stage: decodes the 32-bit instruction and generates the main control signals.
- Contains the 32x64 register file and produces the sign-extended immediate.
- Resolves branches (B, CBZ, CBNZ, optional B.cond) and drives PCSrc/BranchAddress back to the fetch stage.
- Sits between instruction fetch and execute; fetch samples PCSrc/BranchAddress one fetch period after presenting the instruction.

Parameters:
- XLEN, 64, register/PC/data width
- NREGS, 32, architectural registers (X31 = XZR)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instruction  in  32  instruction word, little-endian assembled
- PC  in  64  byte address of instruction
- wb_en  in  1  register-file write enable
- wb_reg  in  5  write register index
- wb_data  in  64  write data
- PCSrc  out  1  1 = take BranchAddress, 0 = PC+4
- BranchAddress  out  64  next-PC target
- read_data1  out  64  Rn value
- read_data2  out  64  Rm or Rt value, selected by Reg2Loc
- imm_ext  out  64  sign-extended immediate
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch  out  1 each  control
- ALUOp  out  2  00 mem, 01 cbz, 10 R-type
- halt  out  1  instruction[31:21] == 11'h7FF

Behaviour:
- Register file:
  - On reset (async), all registers are 0.
  - Writes occur on the rising clk edge when wb_en=1 and wb_reg != 31.
  - Reads are combinational. Index 31 always reads 0.
  - Same-cycle write/read of one register returns the old value until the edge.
- All decode outputs are combinational from instruction, PC and register contents (zero latency).
- Read ports: Rn = [9:5]. Second read index = Reg2Loc ? Rt[4:0] : Rm[20:16].
- Opcode classes:
  - R-type by [31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> RegWrite=1, ALUOp=10, all other controls 0.
  - LDUR 11111000010 -> ALUSrc, MemtoReg, RegWrite, MemRead = 1; ALUOp=00.
  - STUR 11111000000 -> Reg2Loc, ALUSrc, MemWrite = 1; ALUOp=00.
  - CBZ [31:24]=10110100 and CBNZ 10110101 -> Reg2Loc=1, Branch=1, ALUOp=01.
  - B [31:26]=000101 -> UncondBranch=1.
  - Any other encoding (including NOP 0xD503201F and HALT) -> all controls 0.
- imm_ext:
  - D-format: sext(instruction[20:12]).
  - CB-format: sext([23:5]).
  - B: sext([25:0]).
  - Otherwise 0.
- Branch resolution:
  - B: PCSrc=1, BranchAddress = PC + (sext(imm26) << 2).
  - CBZ: PCSrc = (read_data2 == 0). CBNZ: PCSrc = (read_data2 != 0). BranchAddress = PC + (sext(imm19) << 2).
  - Non-branch, or branch not taken: PCSrc=0, BranchAddress = PC+4.
- Arithmetic is modulo 2^64; targets wrap silently. Negative offsets must work.
- During reset, PCSrc=0 and BranchAddress = PC+4. Register reads return 0.
- halt is asserted combinationally; fetch uses it to stop simulation.

Optional Feature:
- Macro: BRANCH_COND_EN.
- Defined:
  - Decode B.cond ([31:24]=01010100, bit4=0).
  - Adds input flags[3:0] (N,Z,C,V).
  - Conditions: EQ 0000, NE 0001, HS 0010, LO 0011, MI 0100, PL 0101, VS 0110, VC 0111, HI 1000, LS 1001, GE 1010, LT 1011, GT 1100, LE 1101, AL 1110/1111.
  - If taken: PCSrc=1, BranchAddress = PC + (sext(imm19) << 2). Branch=1.
- Undefined: B.cond is treated as an unknown encoding (no flags port, controls 0, PCSrc=0).

Decomposition:
- Package legv8_pkg:
  - Opcode constants (R-type, LDUR, STUR, CBZ, CBNZ, B, B.cond, HALT prefix).
  - ALUOp encodings.
  - Condition codes.
  - A packed control-signal struct.
- One natural sub-module: register_file (32x64, async reset, 2 combinational read ports, 1 write port, XZR handling).

Test Plan:
- PC=0x10, instruction=0x14000003 (B +3) -> PCSrc=1, BranchAddress=0x1C, UncondBranch=1.
- Reset, then write X1=0; PC=0x40, CBZ X1 with imm19=-2 (0xB4FFFFC1) -> PCSrc=1, BranchAddress=0x38.
- Write X2=5; CBNZ X2 +4 (0xB5000082) at PC=0x100 -> PCSrc=1, BranchAddress=0x110. Same encoding as CBZ (0xB4000082) -> PCSrc=0, BranchAddress=0x104.
- NOP 0xD503201F at PC=0x8 -> all controls 0, PCSrc=0, BranchAddress=0xC, halt=0.
- LDUR X3,[X1,#8] (0xF8408023) -> ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00, imm_ext=8. Instruction 0xFFE00000 -> halt=1.
- Write X5=0xABCD, then assert reset mid-run -> read of X5 returns 0 immediately. Write to X31 -> X31 still reads 0.

Source files
------------

// File: rtl/legv8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : legv8_pkg
// Purpose  : Shared definitions for the LEGv8 decode stage. Contains opcode
//            field values, ALUOp encodings, branch condition codes, the packed
//            control-signal bundle and the condition-evaluation helper.
// Revision : 1.0  initial release
// ============================================================================
package legv8_pkg;

    // 11-bit opcodes, instruction[31:21]
    localparam logic [10:0] c_op_add  = 11'b10001011000;
    localparam logic [10:0] c_op_sub  = 11'b11001011000;
    localparam logic [10:0] c_op_and  = 11'b10001010000;
    localparam logic [10:0] c_op_orr  = 11'b10101010000;
    localparam logic [10:0] c_op_ldur = 11'b11111000010;
    localparam logic [10:0] c_op_stur = 11'b11111000000;
    localparam logic [10:0] c_op_halt = 11'h7FF;

    // 8-bit opcodes, instruction[31:24]
    localparam logic [7:0]  c_op_cbz   = 8'b10110100;
    localparam logic [7:0]  c_op_cbnz  = 8'b10110101;
    localparam logic [7:0]  c_op_bcond = 8'b01010100;

    // 6-bit opcode, instruction[31:26]
    localparam logic [5:0]  c_op_b = 6'b000101;

    typedef enum logic [1:0] {
        ALUOP_MEM   = 2'b00,
        ALUOP_CBZ   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_HS = 4'b0010,
        COND_LO = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Which immediate field the current instruction carries
    typedef enum logic [1:0] {
        FMT_NONE = 2'b00,
        FMT_D    = 2'b01,
        FMT_CB   = 2'b10,
        FMT_B    = 2'b11
    } imm_fmt_e;

    typedef struct packed {
        logic   reg2loc;
        logic   alusrc;
        logic   memtoreg;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   branch;
        logic   uncondbranch;
        aluop_e aluop;
    } ctrl_t;

    // flags = {N, Z, C, V}
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic res;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond_e'(cond))
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_HS: res = c;
            COND_LO: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~(c & ~z);
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = ~(~z & (n == v));
            default: res = 1'b1;   // AL and NV both mean always
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_decode_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decode_if
// Purpose  : Bundle of the fetch/write-back side signals of the decode stage.
//            master = driver of instruction/PC/write-back (fetch + WB side)
//            slave  = the decode stage itself
// Ports    : instruction, PC, wb_en, wb_reg, wb_data, [flags] -> decode
//            PCSrc, BranchAddress, read_data1/2, imm_ext, controls, ALUOp,
//            halt <- decode
// Options  : BRANCH_COND_EN adds the flags[3:0] (N,Z,C,V) signal.
// Revision : 1.0  initial release
// ============================================================================
interface instruction_decode_if #(
    parameter int XLEN = 64
);
    logic [31:0]     instruction;
    logic [XLEN-1:0] PC;
    logic            wb_en;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] wb_data;
`ifdef BRANCH_COND_EN
    logic [3:0]      flags;
`endif
    logic            PCSrc;
    logic [XLEN-1:0] BranchAddress;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;
    logic [XLEN-1:0] imm_ext;
    logic            Reg2Loc;
    logic            ALUSrc;
    logic            MemtoReg;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            Branch;
    logic            UncondBranch;
    logic [1:0]      ALUOp;
    logic            halt;

`ifdef BRANCH_COND_EN
    modport master (
        output instruction, PC, wb_en, wb_reg, wb_data, flags,
        input  PCSrc, BranchAddress, read_data1, read_data2, imm_ext,
               Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, UncondBranch, ALUOp, halt
    );
    modport slave (
        input  instruction, PC, wb_en, wb_reg, wb_data, flags,
        output PCSrc, BranchAddress, read_data1, read_data2, imm_ext,
               Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, UncondBranch, ALUOp, halt
    );
`else
    modport master (
        output instruction, PC, wb_en, wb_reg, wb_data,
        input  PCSrc, BranchAddress, read_data1, read_data2, imm_ext,
               Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, UncondBranch, ALUOp, halt
    );
    modport slave (
        input  instruction, PC, wb_en, wb_reg, wb_data,
        output PCSrc, BranchAddress, read_data1, read_data2, imm_ext,
               Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               Branch, UncondBranch, ALUOp, halt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/instruction_decode_register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : NREGS x XLEN architectural register file. Index NREGS-1 is the
//            zero register: never stored, always reads 0. Reads are
//            combinational and see the pre-edge value on a same-cycle write.
// Ports    : clk, reset (async, active-high, clears all registers)
//            rs1/rs2 -> rd1/rd2 combinational read ports
//            we/wa/wd synchronous write port
// Revision : 1.0  initial release
// ============================================================================
module register_file #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic [AW-1:0]   rs1,
    input  wire logic [AW-1:0]   rs2,
    input  wire logic            we,
    input  wire logic [AW-1:0]   wa,
    input  wire logic [XLEN-1:0] wd,
    output logic      [XLEN-1:0] rd1,
    output logic      [XLEN-1:0] rd2
);

    logic [XLEN-1:0] r_regs [NREGS-1];
    logic [XLEN-1:0] w_rf   [NREGS];

    generate
        for (genvar i = 0; i < NREGS - 1; i++) begin : g_regs
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_regs[i] <= '0;
                end else if (we && (wa == AW'(i))) begin
                    r_regs[i] <= wd;
                end
            end
            assign w_rf[i] = r_regs[i];
        end
        // Zero register: writes to it simply have no target
        begin : g_xzr
            assign w_rf[NREGS-1] = '0;
        end
    endgenerate

    // Reads are forced to 0 while reset is held so nothing stale leaks out
    // in the window before the clear takes effect.
    assign rd1 = reset ? '0 : w_rf[rs1];
    assign rd2 = reset ? '0 : w_rf[rs2];

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decode
// Purpose  : LEGv8 decode stage. Decodes the instruction word into the main
//            control signals, reads the register file, sign-extends the
//            immediate and resolves B / CBZ / CBNZ (and optionally B.cond),
//            returning PCSrc/BranchAddress to fetch with zero latency.
// Ports    : clk, reset (async, active-high)
//            bus : instruction_decode_if.slave (see interface header)
// Options  : BRANCH_COND_EN enables B.cond decode using bus.flags.
// Revision : 1.0  initial release
// ============================================================================
module instruction_decode
    import legv8_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    instruction_decode_if.slave   bus
);

    logic [10:0]     w_op11;
    logic [7:0]      w_op8;
    logic [5:0]      w_op6;
    logic            w_is_rtype;
    logic            w_is_ldur;
    logic            w_is_stur;
    logic            w_is_cbz;
    logic            w_is_cbnz;
    logic            w_is_b;
    logic            w_is_bcond;
    logic            w_cond_ok;
    ctrl_t           w_ctrl;
    imm_fmt_e        w_fmt;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic            w_take;

    assign w_op11 = bus.instruction[31:21];
    assign w_op8  = bus.instruction[31:24];
    assign w_op6  = bus.instruction[31:26];

    assign w_is_rtype = (w_op11 == c_op_add) || (w_op11 == c_op_sub) ||
                        (w_op11 == c_op_and) || (w_op11 == c_op_orr);
    assign w_is_ldur  = (w_op11 == c_op_ldur);
    assign w_is_stur  = (w_op11 == c_op_stur);
    assign w_is_cbz   = (w_op8  == c_op_cbz);
    assign w_is_cbnz  = (w_op8  == c_op_cbnz);
    assign w_is_b     = (w_op6  == c_op_b);

`ifdef BRANCH_COND_EN
    assign w_is_bcond = (w_op8 == c_op_bcond) && !bus.instruction[4];
    assign w_cond_ok  = cond_holds(bus.instruction[3:0], bus.flags);
`else
    assign w_is_bcond = 1'b0;
    assign w_cond_ok  = 1'b0;
`endif

    // Main control decode; anything unrecognised leaves all controls at 0.
    always_comb begin
        w_ctrl = '0;
        w_fmt  = FMT_NONE;
        if (w_is_rtype) begin
            w_ctrl.regwrite = 1'b1;
            w_ctrl.aluop    = ALUOP_RTYPE;
        end else if (w_is_ldur) begin
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.memtoreg = 1'b1;
            w_ctrl.regwrite = 1'b1;
            w_ctrl.memread  = 1'b1;
            w_ctrl.aluop    = ALUOP_MEM;
            w_fmt           = FMT_D;
        end else if (w_is_stur) begin
            w_ctrl.reg2loc  = 1'b1;
            w_ctrl.alusrc   = 1'b1;
            w_ctrl.memwrite = 1'b1;
            w_ctrl.aluop    = ALUOP_MEM;
            w_fmt           = FMT_D;
        end else if (w_is_cbz || w_is_cbnz) begin
            w_ctrl.reg2loc  = 1'b1;
            w_ctrl.branch   = 1'b1;
            w_ctrl.aluop    = ALUOP_CBZ;
            w_fmt           = FMT_CB;
        end else if (w_is_b) begin
            w_ctrl.uncondbranch = 1'b1;
            w_fmt               = FMT_B;
        end else if (w_is_bcond) begin
            w_ctrl.branch   = 1'b1;
            w_fmt           = FMT_CB;
        end
    end

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FMT_D:   w_imm = {{(XLEN-9){bus.instruction[20]}},  bus.instruction[20:12]};
            FMT_CB:  w_imm = {{(XLEN-19){bus.instruction[23]}}, bus.instruction[23:5]};
            FMT_B:   w_imm = {{(XLEN-26){bus.instruction[25]}}, bus.instruction[25:0]};
            default: w_imm = '0;
        endcase
    end

    // Stores and CB-format take the second operand from the Rt field
    assign w_rs2 = w_ctrl.reg2loc ? bus.instruction[4:0] : bus.instruction[20:16];

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_register_file (
        .clk   (clk),
        .reset (reset),
        .rs1   (bus.instruction[9:5]),
        .rs2   (w_rs2),
        .we    (bus.wb_en),
        .wa    (bus.wb_reg),
        .wd    (bus.wb_data),
        .rd1   (w_rd1),
        .rd2   (w_rd2)
    );

    // Offsets are word counts; the shift and add both wrap modulo 2^XLEN.
    assign w_pc_plus4 = bus.PC + XLEN'(4);
    assign w_target   = bus.PC + (w_imm << 2);

    assign w_take = w_is_b ||
                    (w_is_cbz   && (w_rd2 == '0)) ||
                    (w_is_cbnz  && (w_rd2 != '0)) ||
                    (w_is_bcond && w_cond_ok);

    assign bus.PCSrc         = w_take && !reset;
    assign bus.BranchAddress = bus.PCSrc ? w_target : w_pc_plus4;
    assign bus.read_data1    = w_rd1;
    assign bus.read_data2    = w_rd2;
    assign bus.imm_ext       = w_imm;
    assign bus.Reg2Loc       = w_ctrl.reg2loc;
    assign bus.ALUSrc        = w_ctrl.alusrc;
    assign bus.MemtoReg      = w_ctrl.memtoreg;
    assign bus.RegWrite      = w_ctrl.regwrite;
    assign bus.MemRead       = w_ctrl.memread;
    assign bus.MemWrite      = w_ctrl.memwrite;
    assign bus.Branch        = w_ctrl.branch;
    assign bus.UncondBranch  = w_ctrl.uncondbranch;
    assign bus.ALUOp         = w_ctrl.aluop;
    assign bus.halt          = (w_op11 == c_op_halt);

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decode
// Purpose  : Self-checking bench for instruction_decode. Each scenario task
//            drives an instruction/PC, queues the values the decode stage
//            should present, then drains the queue against the outputs.
// Options  : BRANCH_COND_EN selects the B.cond scenario variant.
// Revision : 1.0  initial release
// ============================================================================
module tb_instruction_decode;

    localparam int K_PCSRC = 0;
    localparam int K_BADDR = 1;
    localparam int K_CTRL  = 2;   // {Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,UncondBranch,ALUOp}
    localparam int K_IMM   = 3;
    localparam int K_HALT  = 4;
    localparam int K_RD1   = 5;
    localparam int K_RD2   = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    instruction_decode_if #(.XLEN(64)) bus ();

    instruction_decode #(
        .XLEN  (64),
        .NREGS (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            K_PCSRC: return {63'd0, bus.PCSrc};
            K_BADDR: return bus.BranchAddress;
            K_CTRL:  return {54'd0, bus.Reg2Loc, bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
                             bus.MemRead, bus.MemWrite, bus.Branch, bus.UncondBranch, bus.ALUOp};
            K_IMM:   return bus.imm_ext;
            K_HALT:  return {63'd0, bus.halt};
            K_RD1:   return bus.read_data1;
            K_RD2:   return bus.read_data2;
            default: return 64'hDEAD;
        endcase
    endfunction

    function automatic void push(input string n, input int k, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [63:0] pc);
        @(negedge clk);
        bus.instruction = ins;
        bus.PC          = pc;
    endtask

    task automatic wr_reg(input logic [4:0] r, input logic [63:0] d);
        @(negedge clk);
        bus.wb_en   = 1'b1;
        bus.wb_reg  = r;
        bus.wb_data = d;
        @(negedge clk);
        bus.wb_en   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.instruction = 32'h14000003;
        bus.PC          = 64'h10;
        #2;
        push("rst_pcsrc", K_PCSRC, 64'd0);
        push("rst_baddr", K_BADDR, 64'h14);
        push("rst_rd1",   K_RD1,   64'd0);
        push("rst_rd2",   K_RD2,   64'd0);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_b();
        drive(32'h14000003, 64'h10);
        push("b_pcsrc", K_PCSRC, 64'd1);
        push("b_baddr", K_BADDR, 64'h1C);
        push("b_ctrl",  K_CTRL,  64'b00_0000_0100);
        push("b_imm",   K_IMM,   64'd3);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
    endtask

    task automatic test_cbz_cbnz();
        pulse_reset();
        wr_reg(5'd1, 64'd0);
        drive(32'hB4FFFFC1, 64'h40);
        push("cbz_neg_pcsrc", K_PCSRC, 64'd1);
        push("cbz_neg_baddr", K_BADDR, 64'h38);
        push("cbz_neg_ctrl",  K_CTRL,  64'b10_0000_1001);
        push("cbz_neg_imm",   K_IMM,   64'hFFFF_FFFF_FFFF_FFFE);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        wr_reg(5'd2, 64'd5);
        drive(32'hB5000082, 64'h100);
        push("cbnz_pcsrc", K_PCSRC, 64'd1);
        push("cbnz_baddr", K_BADDR, 64'h110);
        push("cbnz_rd2",   K_RD2,   64'd5);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        drive(32'hB4000082, 64'h100);
        push("cbz_nt_pcsrc", K_PCSRC, 64'd0);
        push("cbz_nt_baddr", K_BADDR, 64'h104);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
    endtask

    task automatic test_nop();
        drive(32'hD503201F, 64'h8);
        push("nop_ctrl",  K_CTRL,  64'd0);
        push("nop_pcsrc", K_PCSRC, 64'd0);
        push("nop_baddr", K_BADDR, 64'hC);
        push("nop_halt",  K_HALT,  64'd0);
        push("nop_imm",   K_IMM,   64'd0);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
    endtask

    task automatic test_mem_rtype_halt();
        wr_reg(5'd1, 64'h1234);
        // LDUR X3,[X1,#8]
        drive(32'hF8408023, 64'h20);
        push("ldur_ctrl", K_CTRL, 64'b01_1110_0000);
        push("ldur_imm",  K_IMM,  64'd8);
        push("ldur_rd1",  K_RD1,  64'h1234);
        push("ldur_halt", K_HALT, 64'd0);
        // STUR X2,[X1,#-1]
        push("stur_ctrl", K_CTRL, 64'b11_0001_0000);
        push("stur_imm",  K_IMM,  64'hFFFF_FFFF_FFFF_FFFF);
        push("stur_rd2",  K_RD2,  64'd5);
        // ADD X3,X1,X2
        push("add_ctrl",  K_CTRL, 64'b00_0100_0010);
        push("add_rd1",   K_RD1,  64'h1234);
        push("add_rd2",   K_RD2,  64'd5);
        push("add_imm",   K_IMM,  64'd0);
        // HALT
        push("halt_halt", K_HALT, 64'd1);
        push("halt_ctrl", K_CTRL, 64'd0);
        push("halt_pcsrc", K_PCSRC, 64'd0);
        #2;
        for (int i = 0; i < 4; i++) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        drive(32'hF81FF022, 64'h24);
        #2;
        for (int i = 0; i < 3; i++) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        drive(32'h8B020023, 64'h28);
        #2;
        for (int i = 0; i < 4; i++) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        drive(32'hFFE00000, 64'h2C);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        wr_reg(5'd5, 64'hABCD);
        drive(32'h8B0000A0, 64'h30);   // Rn = X5
        push("x5_before", K_RD1, 64'hABCD);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        push("x5_in_reset", K_RD1, 64'd0);
        #1;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        push("x5_after_reset", K_RD1, 64'd0);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
    endtask

    task automatic test_xzr_and_write_timing();
        wr_reg(5'd31, 64'hFFFF);
        drive(32'h8B1F03E0, 64'h0);    // Rn = X31, Rm = X31
        push("xzr_rd1", K_RD1, 64'd0);
        push("xzr_rd2", K_RD2, 64'd0);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        wr_reg(5'd6, 64'd1);
        drive(32'h8B0000C0, 64'h0);    // Rn = X6
        bus.wb_en   = 1'b1;
        bus.wb_reg  = 5'd6;
        bus.wb_data = 64'd2;
        push("wr_old_value", K_RD1, 64'd1);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0;
        push("wr_new_value", K_RD1, 64'd2);
        #1;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] imm;
        logic [63:0] pc;
        logic [63:0] sext;
        for (int i = 0; i < 8; i++) begin
            imm = 26'($urandom);
            pc  = {$urandom, $urandom} & ~64'h3;
            if (i == 0) begin
                // forward wrap past the top of the address space
                imm = 26'd1;
                pc  = 64'hFFFF_FFFF_FFFF_FFFC;
            end
            sext = {{38{imm[25]}}, imm};
            drive({6'b000101, imm}, pc);
            push("b2b_pcsrc", K_PCSRC, 64'd1);
            push("b2b_baddr", K_BADDR, pc + sext * 64'd4);
            push("b2b_imm",   K_IMM,   sext);
            #2;
            while (sb.size() > 0) begin
                exp_t e = sb.pop_front();
                n_tests++;
                if (observe(e.kind) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %0h expected %0h", e.name, i, observe(e.kind), e.val);
                end
            end
        end
    endtask

    task automatic test_bcond();
`ifdef BRANCH_COND_EN
        bus.flags = 4'b0100;           // Z set
        drive(32'h54000040, 64'h200);  // B.EQ +2
        push("beq_t_pcsrc", K_PCSRC, 64'd1);
        push("beq_t_baddr", K_BADDR, 64'h208);
        push("beq_t_ctrl",  K_CTRL,  64'b00_0000_1000);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        bus.flags = 4'b0000;
        push("beq_nt_pcsrc", K_PCSRC, 64'd0);
        push("beq_nt_baddr", K_BADDR, 64'h204);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
        bus.flags = 4'b1001;           // N=1, V=1, Z=0 -> GT holds
        drive(32'h5400004C, 64'h200);
        push("bgt_pcsrc", K_PCSRC, 64'd1);
        push("bgt_baddr", K_BADDR, 64'h208);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
`else
        drive(32'h54000040, 64'h200);
        push("bcond_off_ctrl",  K_CTRL,  64'd0);
        push("bcond_off_pcsrc", K_PCSRC, 64'd0);
        push("bcond_off_baddr", K_BADDR, 64'h204);
        push("bcond_off_imm",   K_IMM,   64'd0);
        #2;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            n_tests++;
            if (observe(e.kind) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", e.name, observe(e.kind), e.val);
            end
        end
`endif
    endtask

    initial begin
        reset           = 1'b1;
        bus.instruction = 32'd0;
        bus.PC          = 64'd0;
        bus.wb_en       = 1'b0;
        bus.wb_reg      = 5'd0;
        bus.wb_data     = 64'd0;
`ifdef BRANCH_COND_EN
        bus.flags       = 4'd0;
`endif
        test_reset();
        test_b();
        test_cbz_cbnz();
        test_nop();
        test_mem_rtype_halt();
        test_reset_mid();
        test_xzr_and_write_timing();
        test_back_to_back();
        test_bcond();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
